// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the ALU sequencer: FSM state
//                encoding, ALU control codes, jump condition codes and
//                instruction field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Sequencer FSM states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_OPERAND = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } seq_state_t;

    // ALU control codes
    localparam logic [2:0] ALU_NAND = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SHR  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;
    localparam logic [2:0] ALU_ADD  = 3'b110;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    // Control-flow condition codes (kk field)
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_ZF     = 2'b01;
    localparam logic [1:0] COND_CF     = 2'b10;
    localparam logic [1:0] COND_HALT   = 2'b11;

    // Instruction class in bits [7:6]; ALU ops are 0?
    localparam logic [1:0] CLASS_LI   = 2'b10;
    localparam logic [1:0] CLASS_CTRL = 2'b11;

    // Instruction field LSB positions
    localparam int unsigned IR_CLASS_LSB = 6;
    localparam int unsigned IR_CTRL_LSB  = 4;
    localparam int unsigned IR_RA_LSB    = 2;
    localparam int unsigned IR_RB_LSB    = 0;
    localparam int unsigned IR_RD_LSB    = 4;
    localparam int unsigned IR_COND_LSB  = 4;

    // True when a control-flow condition is satisfied by the current flags
    function automatic logic cond_met(input logic [1:0] cond, input logic zf, input logic cf);
        logic met;
        met = 1'b0;
        case (cond)
            COND_ALWAYS: met = 1'b1;
            COND_ZF:     met = zf;
            COND_CF:     met = cf;
            default:     met = 1'b0;
        endcase
        return met;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : seq_regfile
//  Description : 4 x 8-bit register file, two asynchronous read ports and one
//                synchronous write port, synchronous reset to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_regfile (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_rd_addr_a,
    output logic [7:0] o_rd_data_a,
    input  logic [1:0] i_rd_addr_b,
    output logic [7:0] o_rd_data_b,
    input  logic       i_wr_en,
    input  logic [1:0] i_wr_addr,
    input  logic [7:0] i_wr_data
);

    logic [7:0] r_regs [4];

    // Register storage: clear on reset, single write port otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (i_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_a = r_regs[i_rd_addr_a];
    assign o_rd_data_b = r_regs[i_rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Control unit for the 8-bit ALU. Fetches byte instructions
//                over a req/valid port, holds a 4x8 register file, issues one
//                ALU operation per instruction and jumps on zf/cf.
//                Optional single-step mode: define ALU_SEQ_SINGLE_STEP_EN to
//                add the step input that gates each instruction fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [7:0] RESET_PC        = 8'h00,
    parameter bit         HALT_ON_INVALID = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
`ifdef ALU_SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic [7:0] mem_data,
    input  logic       mem_valid,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_control,
    output logic       alu_execute,
    input  logic [7:0] alu_out,
    input  logic       alu_zf,
    input  logic       alu_cf,
    output logic       halted
);

    seq_state_t r_state, w_state_next;
    logic [7:0] r_pc, r_ir, w_pc_next;
    logic       r_mem_req, w_mem_req_next;
    logic [7:0] r_alu_a, r_alu_b;
    logic [2:0] r_alu_control;
    logic       r_alu_execute, r_halted;

    logic       w_fire, w_taken, w_is_alu;
    logic [1:0] w_class, w_ra, w_rb, w_rd, w_cond;
    logic [2:0] w_ctrl;
    logic [7:0] w_rd_a, w_rd_b;
    logic       w_rf_we;
    logic [1:0] w_rf_waddr;
    logic [7:0] w_rf_wdata;

    // Instruction fields
    assign w_class  = r_ir[IR_CLASS_LSB +: 2];
    assign w_ctrl   = r_ir[IR_CTRL_LSB +: 3];
    assign w_ra     = r_ir[IR_RA_LSB +: 2];
    assign w_rb     = r_ir[IR_RB_LSB +: 2];
    assign w_rd     = r_ir[IR_RD_LSB +: 2];
    assign w_cond   = r_ir[IR_COND_LSB +: 2];
    assign w_is_alu = ~r_ir[7];

    // A byte is accepted only while our own request is up
    assign w_fire  = r_mem_req & mem_valid;
    assign w_taken = (w_class == CLASS_CTRL) & cond_met(w_cond, alu_zf, alu_cf);

    seq_regfile u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr_a (w_ra),
        .o_rd_data_a (w_rd_a),
        .i_rd_addr_b (w_rb),
        .o_rd_data_b (w_rd_b),
        .i_wr_en     (w_rf_we),
        .i_wr_addr   (w_rf_waddr),
        .i_wr_data   (w_rf_wdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH:   if (w_fire) w_state_next = ST_DECODE;
            ST_DECODE: begin
                casez (w_class)
                    2'b0?:      w_state_next = ST_EXEC;
                    CLASS_LI:   w_state_next = ST_OPERAND;
                    CLASS_CTRL: w_state_next = (w_cond == COND_HALT) ? ST_HALT : ST_OPERAND;
                    default:    w_state_next = HALT_ON_INVALID ? ST_HALT : ST_FETCH;
                endcase
            end
            ST_OPERAND: if (w_fire) w_state_next = ST_FETCH;
            ST_EXEC:    w_state_next = ST_WB;
            ST_WB:      w_state_next = ST_FETCH;
            ST_HALT:    w_state_next = ST_HALT;
            default:    w_state_next = ST_FETCH;
        endcase
    end

    // Output / datapath next values: pc, fetch request, register write-back
    always_comb begin
        w_pc_next = r_pc;
        if (w_fire && r_state == ST_FETCH) begin
            w_pc_next = r_pc + 8'd1;
        end else if (w_fire && r_state == ST_OPERAND) begin
            w_pc_next = w_taken ? mem_data : r_pc + 8'd1;
        end

`ifdef ALU_SEQ_SINGLE_STEP_EN
        // Operand fetches run freely; instruction fetches wait for a step pulse
        w_mem_req_next = (w_state_next == ST_OPERAND) ||
                         ((r_state == ST_FETCH) && (w_state_next == ST_FETCH) && (r_mem_req || step));
`else
        // Request is raised on entry so a zero-wait memory completes in one cycle
        w_mem_req_next = (w_state_next == ST_FETCH) || (w_state_next == ST_OPERAND);
`endif

        w_rf_we    = 1'b0;
        w_rf_waddr = w_rd;
        w_rf_wdata = mem_data;
        if (r_state == ST_WB) begin
            w_rf_we    = (w_ctrl != ALU_CMP);
            w_rf_waddr = w_ra;
            w_rf_wdata = alu_out;
        end else if (r_state == ST_OPERAND && w_fire && w_class == CLASS_LI) begin
            w_rf_we = 1'b1;
        end
    end

    // Registered outputs and instruction/pc state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_ir          <= 8'h00;
            r_mem_req     <= 1'b0;
            r_alu_a       <= 8'h00;
            r_alu_b       <= 8'h00;
            r_alu_control <= ALU_PASS;
            r_alu_execute <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_mem_req     <= w_mem_req_next;
            r_alu_execute <= (w_state_next == ST_EXEC);
            r_halted      <= (w_state_next == ST_HALT);
            if (r_state == ST_FETCH && w_fire) begin
                r_ir <= mem_data;
            end
            if (r_state == ST_DECODE && w_is_alu) begin
                r_alu_a       <= w_rd_a;
                r_alu_b       <= w_rd_b;
                r_alu_control <= w_ctrl;
            end
        end
    end

    assign mem_addr    = r_pc;
    assign mem_req     = r_mem_req;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;
    assign alu_execute = r_alu_execute;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer with a behavioural
//                program memory (configurable wait states) and ALU model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b1;
    logic [7:0] mem_addr, mem_data, alu_a, alu_b, alu_out;
    logic       mem_req, mem_valid, alu_execute, alu_zf, alu_cf, halted;
    logic [2:0] alu_control;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [256];
    int         lat = 0;
    int         wait_cnt = 0;
    logic       spurious = 1'b0;

    logic [7:0]  obs_fetch[$], exp_fetch[$];
    logic [18:0] obs_alu[$], exp_alu[$];

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
`ifdef ALU_SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_execute (alu_execute),
        .alu_out     (alu_out),
        .alu_zf      (alu_zf),
        .alu_cf      (alu_cf),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Program memory: valid after lat waiting cycles; optional spurious valid while idle
    assign mem_valid = mem_req ? (wait_cnt >= lat) : spurious;
    assign mem_data  = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_req && !mem_valid) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    // ALU model: registered result, flags updated by compare only
    always @(posedge clk) begin
        if (rst) begin
            alu_out <= 8'h00; alu_zf <= 1'b0; alu_cf <= 1'b0;
        end else if (alu_execute) begin
            case (alu_control)
                3'b000:  alu_out <= ~(alu_a & alu_b);
                3'b001:  alu_out <= alu_a & alu_b;
                3'b010:  alu_out <= alu_a ^ alu_b;
                3'b011:  alu_out <= alu_a >> 1;
                3'b100:  alu_out <= alu_b;
                3'b110:  alu_out <= alu_a + alu_b;
                default: alu_out <= alu_out;
            endcase
            if (alu_control == 3'b111) begin
                alu_zf <= (alu_a == alu_b);
                alu_cf <= (alu_a < alu_b);
            end
        end
    end

    // Monitor: collect accepted fetch addresses and issued ALU operations
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_valid) obs_fetch.push_back(mem_addr);
            if (alu_execute)          obs_alu.push_back({alu_a, alu_b, alu_control});
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_fetch.delete(); obs_alu.delete(); exp_fetch.delete(); exp_alu.delete();
    endtask

    task automatic run_until_halted(input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk); n++;
        end
        tests++;
        if (halted !== 1'b1) begin
            fails++; $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, n);
        end
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h05; mem[2] = 8'h90;
        mem[3] = 8'h03; mem[4] = 8'h61; mem[5] = 8'hC0;
    endtask

    task automatic test_reset();
        rst = 1'b1; lat = 0; spurious = 1'b0; clear_mem();
        repeat (3) @(negedge clk);
        tests++; if (mem_req !== 1'b0)        begin fails++; $display("FAIL reset_mem_req: got %0b, required 0", mem_req); end
        tests++; if (mem_addr !== 8'h00)      begin fails++; $display("FAIL reset_mem_addr: got %02h, required 00", mem_addr); end
        tests++; if (alu_a !== 8'h00)         begin fails++; $display("FAIL reset_alu_a: got %02h, required 00", alu_a); end
        tests++; if (alu_b !== 8'h00)         begin fails++; $display("FAIL reset_alu_b: got %02h, required 00", alu_b); end
        tests++; if (alu_control !== 3'b100)  begin fails++; $display("FAIL reset_alu_control: got %03b, required 100", alu_control); end
        tests++; if (alu_execute !== 1'b0)    begin fails++; $display("FAIL reset_alu_execute: got %0b, required 0", alu_execute); end
        tests++; if (halted !== 1'b0)         begin fails++; $display("FAIL reset_halted: got %0b, required 0", halted); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (dut.u_regfile.r_regs[i] !== 8'h00) begin
                fails++; $display("FAIL reset_r%0d: got %02h, required 00", i, dut.u_regfile.r_regs[i]);
            end
        end
    endtask

    task automatic test_add_program(input int wait_states);
        load_prog1(); lat = wait_states; spurious = (wait_states != 0);
        apply_reset();
        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hF0};
        exp_alu.push_back({8'd5, 8'd3, 3'b110});
        if (wait_states != 0) begin
            int n = 0;
            while (mem_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
            for (int k = 0; k < wait_states; k++) begin
                tests++;
                if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
                    fails++; $display("FAIL wait_hold[%0d]: req=%0b addr=%02h, required req=1 addr=00", k, mem_req, mem_addr);
                end
                @(negedge clk);
            end
        end
        run_until_halted(300);
        tests++;
        if (obs_fetch.size() != exp_fetch.size()) begin
            fails++; $display("FAIL add_fetch_count: got %0d, required %0d", obs_fetch.size(), exp_fetch.size());
        end
        while (obs_fetch.size() > 0 && exp_fetch.size() > 0) begin
            logic [7:0] o, e;
            o = obs_fetch.pop_front(); e = exp_fetch.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL add_fetch_addr: got %02h, required %02h", o, e); end
        end
        tests++;
        if (obs_alu.size() != 1) begin
            fails++; $display("FAIL add_alu_count: got %0d, required 1", obs_alu.size());
        end else begin
            logic [18:0] o, e;
            o = obs_alu.pop_front(); e = exp_alu.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL add_alu_issue: got %05h, required %05h", o, e); end
        end
        tests++; if (dut.u_regfile.r_regs[0] !== 8'd8) begin fails++; $display("FAIL add_r0: got %02h, required 08", dut.u_regfile.r_regs[0]); end
        tests++; if (dut.u_regfile.r_regs[1] !== 8'd3) begin fails++; $display("FAIL add_r1: got %02h, required 03", dut.u_regfile.r_regs[1]); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (mem_req !== 1'b0 || halted !== 1'b1) begin
                fails++; $display("FAIL halt_hold[%0d]: req=%0b halted=%0b, required req=0 halted=1", k, mem_req, halted);
            end
        end
    endtask

    task automatic test_cmp_jump(input logic [7:0] va, input logic [7:0] vb);
        logic [7:0] o, e;
        logic [18:0] oa, ea;
        clear_mem(); lat = 0; spurious = 1'b0;
        mem[0] = 8'h80; mem[1] = va; mem[2] = 8'h90; mem[3] = vb;
        mem[4] = 8'h71; mem[5] = 8'hD0; mem[6] = 8'h20; mem[7] = 8'hE0; mem[8] = 8'h30;
        apply_reset();
        for (int i = 0; i < 7; i++) exp_fetch.push_back(8'(i));
        if (va == vb) exp_fetch.push_back(8'h20);
        else if (va < vb) begin exp_fetch.push_back(8'h07); exp_fetch.push_back(8'h08); exp_fetch.push_back(8'h30); end
        else begin exp_fetch.push_back(8'h07); exp_fetch.push_back(8'h08); exp_fetch.push_back(8'h09); end
        exp_alu.push_back({va, vb, 3'b111});
        run_until_halted(200);
        tests++;
        if (obs_fetch.size() != exp_fetch.size()) begin
            fails++; $display("FAIL cmp_fetch_count: got %0d, required %0d", obs_fetch.size(), exp_fetch.size());
        end
        while (obs_fetch.size() > 0 && exp_fetch.size() > 0) begin
            o = obs_fetch.pop_front(); e = exp_fetch.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL cmp_fetch_addr: got %02h, required %02h", o, e); end
        end
        tests++;
        if (obs_alu.size() != 1) begin
            fails++; $display("FAIL cmp_alu_count: got %0d, required 1", obs_alu.size());
        end else begin
            oa = obs_alu.pop_front(); ea = exp_alu.pop_front();
            tests++; if (oa !== ea) begin fails++; $display("FAIL cmp_alu_issue: got %05h, required %05h", oa, ea); end
        end
        tests++;
        if (dut.u_regfile.r_regs[0] !== va) begin
            fails++; $display("FAIL cmp_no_writeback: r0=%02h, required %02h", dut.u_regfile.r_regs[0], va);
        end
    endtask

    task automatic test_pc_wrap();
        int n = 0;
        logic [7:0] o, e;
        clear_mem(); lat = 0; spurious = 1'b0;
        mem[0] = 8'hC0; mem[1] = 8'hFF; mem[8'hFF] = 8'h41;
        apply_reset();
        exp_fetch = '{8'h00, 8'h01, 8'hFF, 8'h00};
        exp_alu.push_back({8'h00, 8'h00, 3'b100});
        while (obs_fetch.size() < 4 && n < 60) begin @(negedge clk); n++; end
        tests++;
        if (obs_fetch.size() < 4) begin
            fails++; $display("FAIL wrap_timeout: got %0d fetches, required 4", obs_fetch.size());
        end
        while (obs_fetch.size() > 0 && exp_fetch.size() > 0) begin
            o = obs_fetch.pop_front(); e = exp_fetch.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL wrap_fetch_addr: got %02h, required %02h", o, e); end
        end
        tests++;
        if (obs_alu.size() < 1 || obs_alu[0] !== exp_alu[0]) begin
            fails++; $display("FAIL wrap_alu_issue: got %0d ops, required op %05h", obs_alu.size(), exp_alu[0]);
        end
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        load_prog1(); lat = 0; spurious = 1'b0;
        apply_reset();
        while (alu_execute !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        tests++; if (alu_execute !== 1'b1) begin fails++; $display("FAIL mid_exec_timeout: alu_execute=%0b, required 1", alu_execute); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (mem_req !== 1'b0)     begin fails++; $display("FAIL mid_exec_req: got %0b, required 0", mem_req); end
        tests++; if (alu_execute !== 1'b0) begin fails++; $display("FAIL mid_exec_strobe: got %0b, required 0", alu_execute); end
        tests++; if (mem_addr !== 8'h00)   begin fails++; $display("FAIL mid_exec_pc: got %02h, required 00", mem_addr); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (dut.u_regfile.r_regs[i] !== 8'h00) begin
                fails++; $display("FAIL mid_exec_r%0d: got %02h, required 00", i, dut.u_regfile.r_regs[i]);
            end
        end
        // Reset arriving together with the operand byte of the first load
        lat = 3;
        apply_reset();
        n = 0;
        while (!(mem_req === 1'b1 && mem_valid === 1'b1 && mem_addr === 8'h01) && n < 60) begin @(negedge clk); n++; end
        tests++; if (mem_addr !== 8'h01) begin fails++; $display("FAIL mid_fetch_timeout: addr=%02h, required 01", mem_addr); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (dut.u_regfile.r_regs[0] !== 8'h00) begin fails++; $display("FAIL mid_fetch_r0: got %02h, required 00", dut.u_regfile.r_regs[0]); end
        tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL mid_fetch_req: got %0b, required 0", mem_req); end
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL mid_fetch_pc: got %02h, required 00", mem_addr); end
        rst = 1'b0;
        obs_fetch.delete(); obs_alu.delete();
        run_until_halted(300);
        tests++; if (obs_fetch.size() != 8) begin fails++; $display("FAIL restart_fetch_count: got %0d, required 8", obs_fetch.size()); end
        tests++; if (dut.u_regfile.r_regs[0] !== 8'd8) begin fails++; $display("FAIL restart_r0: got %02h, required 08", dut.u_regfile.r_regs[0]); end
    endtask

    initial begin
        test_reset();
        test_add_program(0);
        test_cmp_jump(8'd7, 8'd7);
        test_cmp_jump(8'd3, 8'd5);
        test_cmp_jump(8'd9, 8'd4);
        test_add_program(3);
        test_pc_wrap();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
